// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, synchronous flush with bubble insertion, optional 2-entry skid.
// Latency 1 cycle (input transfer at edge N is visible on out_data_o in cycle N+1); one transfer per cycle sustained.
// Backpressure: SKID=1 absorbs one extra beat and drives in_ready_o from a register; SKID=0 passes out_ready_i through combinationally.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             squash every held entry and the beat presented this cycle
//   in_valid_i/in_ready_o/in_data_i      upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o   downstream handshake and payload of the oldest entry
//   count_o             number of live entries (0..1 for SKID=0, 0..2 for SKID=1)
module pipe_stage_reg #(
    parameter int              DATA_W = 96,
    parameter bit              SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] main_q, main_d;
    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              skid_vld_q, skid_vld_d;
    logic              in_fire;
    logic              out_fire;

    // With a skid entry, ready is purely the registered "skid empty" flag so
    // there is no combinational path from out_ready_i back to in_ready_o.
    assign in_ready_o  = SKID ? !skid_vld_q : (!main_vld_q || out_ready_i);
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;
    assign count_o     = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = main_vld_q && out_ready_i;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            // Incoming beat is dropped even when in_fire is true.
            main_d     = BUBBLE;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_fire) begin
            if (skid_vld_q) begin
                // in_ready_o is low here, so no input can arrive this cycle.
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                main_d = in_data_i;
            end else begin
                // Emptying keeps the last payload on out_data_o.
                main_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_vld_q) begin
                main_d     = in_data_i;
                main_vld_d = 1'b1;
            end else if (SKID) begin
                // Main is full and stalled: park the beat behind it.
                skid_d     = in_data_i;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= BUBBLE;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: SKID=1 and SKID=0 instances driven by shared stimulus.
// Queue-based reference model checked on every cycle, plus literal expectations.
// Inputs change just after the falling edge; outputs are compared on the falling edge.
module tb_pipe_stage_reg;

    localparam logic [15:0] BUB1 = 16'hB0B0;
    localparam logic [15:0] BUB0 = 16'h0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        rdy1, vld1, rdy0, vld0;
    logic [15:0] dat1, dat0;
    logic [1:0]  cnt1, cnt0;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(16), .SKID(1'b1), .BUBBLE(BUB1)) u_skid (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
        .out_valid_o(vld1), .out_ready_i(out_ready), .out_data_o(dat1),
        .count_o(cnt1)
    );

    pipe_stage_reg #(.DATA_W(16), .SKID(1'b0), .BUBBLE(BUB0)) u_pass (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
        .out_valid_o(vld0), .out_ready_i(out_ready), .out_data_o(dat0),
        .count_o(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each stage is a FIFO of capacity 2 (skid) or 1 (pass-through); the
    // displayed payload is the oldest entry, or the last one seen once empty.
    logic [15:0] q1[$];
    logic [15:0] q0[$];
    logic [15:0] last1, last0;
    bit          chk_en = 1'b0;

    function automatic bit m_rdy1();
        return q1.size() < 2;
    endfunction

    function automatic bit m_rdy0();
        return (q0.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin
        bit of1, if1, of0, if0;
        if (rst) begin
            q1.delete(); q0.delete();
            last1 = BUB1; last0 = BUB0;
            chk_en = 1'b1;
        end else if (flush) begin
            q1.delete(); q0.delete();
            last1 = BUB1; last0 = BUB0;
        end else begin
            of1 = (q1.size() > 0) && out_ready;
            if1 = in_valid && m_rdy1();
            of0 = (q0.size() > 0) && out_ready;
            if0 = in_valid && m_rdy0();
            if (of1) void'(q1.pop_front());
            if (if1) q1.push_back(in_data);
            if (of0) void'(q0.pop_front());
            if (if0) q0.push_back(in_data);
            if (q1.size() > 0) last1 = q1[0];
            if (q0.size() > 0) last0 = q0[0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("skid.in_ready",  {31'b0, rdy1}, {31'b0, m_rdy1()});
            chk("skid.out_valid", {31'b0, vld1}, {31'b0, q1.size() > 0});
            chk("skid.out_data",  {16'b0, dat1}, {16'b0, (q1.size() > 0) ? q1[0] : last1});
            chk("skid.count",     {30'b0, cnt1}, 32'(q1.size()));
            chk("pass.in_ready",  {31'b0, rdy0}, {31'b0, m_rdy0()});
            chk("pass.out_valid", {31'b0, vld0}, {31'b0, q0.size() > 0});
            chk("pass.out_data",  {16'b0, dat0}, {16'b0, (q0.size() > 0) ? q0[0] : last0});
            chk("pass.count",     {30'b0, cnt0}, 32'(q0.size()));
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a falling edge; applies inputs for one rising edge.
    task automatic tick(input logic r, input logic f, input logic v,
                        input logic [15:0] d, input logic o);
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
        @(negedge clk); #1;
    endtask

    localparam logic [5:0] TOGGLE = 6'b101101;

    initial begin
        logic [5:0] pat;
        pat = TOGGLE;

        // Reset held two cycles with a live input presented.
        tick(1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0);
        chk("rst.out_valid", {31'b0, vld1}, 32'd0);
        chk("rst.out_data",  {16'b0, dat1}, {16'b0, BUB1});
        chk("rst.count",     {30'b0, cnt1}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst.in_ready_skid", {31'b0, rdy1}, 32'd1);
        chk("rst.in_ready_pass", {31'b0, rdy0}, 32'd1);

        // Streaming: output follows one cycle later, no gaps.
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b0, 1'b1, 16'(i), 1'b1);
            chk("stream.skid_data", {16'b0, dat1}, 32'(i));
            chk("stream.skid_cnt",  {30'b0, cnt1}, 32'd1);
            chk("stream.pass_data", {16'b0, dat0}, 32'(i));
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain.count", {30'b0, cnt1}, 32'd0);
        chk("drain.keep",  {16'b0, dat1}, 32'd8);

        // Skid fill and drain.
        tick(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 16'h0011, 1'b0);
        chk("skid.full_cnt",  {30'b0, cnt1}, 32'd2);
        chk("skid.full_rdy",  {31'b0, rdy1}, 32'd0);
        chk("skid.head",      {16'b0, dat1}, 32'h10);
        chk("pass.held",      {16'b0, dat0}, 32'h10);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("skid.second",    {16'b0, dat1}, 32'h11);
        chk("skid.rdy_back",  {31'b0, rdy1}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("skid.empty",     {31'b0, vld1}, 32'd0);

        // Flush with a simultaneous input.
        tick(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 16'h0021, 1'b0);
        chk("flush.pre_cnt", {30'b0, cnt1}, 32'd2);
        tick(1'b0, 1'b1, 1'b1, 16'h0055, 1'b0);
        chk("flush.valid", {31'b0, vld1}, 32'd0);
        chk("flush.data",  {16'b0, dat1}, {16'b0, BUB1});
        chk("flush.count", {30'b0, cnt1}, 32'd0);
        chk("flush.pass_data", {16'b0, dat0}, {16'b0, BUB0});
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("flush.no55", {31'b0, vld1}, 32'd0);

        // Stall stability.
        tick(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            chk("stall.data",  {16'b0, dat1}, 32'hDEAD);
            chk("stall.valid", {31'b0, vld1}, 32'd1);
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Pass-through ready with main full and out_ready toggling.
        tick(1'b0, 1'b0, 1'b1, 16'h0030, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rst = 1'b0; flush = 1'b0; in_valid = 1'b1;
            in_data = 16'(16'h0031 + i); out_ready = pat[i];
            #1;
            chk("pass.rdy_follow", {31'b0, rdy0}, {31'b0, pat[i]});
            @(negedge clk); #1;
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset in the middle of traffic.
        tick(1'b0, 1'b0, 1'b1, 16'h0066, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 16'h0077, 1'b1);
        chk("midrst.count", {30'b0, cnt1}, 32'd0);
        chk("midrst.data",  {16'b0, dat1}, {16'b0, BUB1});

        // Random traffic checked by the model.
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined RISC-V datapath. It generalises the fixed IF/ID latch into a width-configurable stage with a valid/ready handshake, synchronous flush with bubble insertion, and an optional two-entry skid buffer. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying a concatenated payload such as {inst, pc, pc4}.

## Interface
- DATA_W, 96, payload width in bits (for example 3 x 32 for {inst, pc, pc4}).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready pass-through.
- BUBBLE, {DATA_W{1'b0}}, value driven on out_data after reset or flush.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high; clock clk.
- flush  in  1  synchronous squash of all held and incoming entries.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  DATA_W  payload of the oldest entry.
- count  out  2  number of entries held (0..1 when SKID=0, 0..2 when SKID=1).

## Operation
- Storage: main register (feeds out_data) and, when SKID=1, a skid register. Entries leave in arrival order.
- Reset values: out_valid=0, out_data=BUBBLE, count=0, skid empty. in_ready=1 in the cycle after rst (SKID=1); in_ready=1 combinationally (SKID=0).
- Priority per cycle: rst, then flush, then normal handshake.
- flush: clears all entries, sets out_data=BUBBLE and out_valid=0, and discards any in_data presented that cycle, even if in_valid && in_ready. in_ready is not masked by flush.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On an input transfer, main loads in_data and out_valid=1.
  - On an output transfer with no input, out_valid=0 and out_data keeps its last value.
- SKID=1:
  - in_ready = registered "skid empty". There is no combinational path from out_ready to in_ready.
  - Input transfer when main is empty, or main is draining this cycle: load main.
  - Input transfer when main is full and not draining: load skid. in_ready deasserts next cycle.
  - Output transfer while skid is full: skid moves to main and in_ready reasserts next cycle.
  - Simultaneous input and output transfers with skid full cannot occur, because in_ready=0 in that state.
- count = number of live entries. count never exceeds capacity; an overflow attempt is impossible under the protocol.
- Payload is opaque: no width conversion, no arithmetic.

## Timing
- Latency: in transfer at edge N gives out_valid=1 with that data after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle sustained when out_ready=1, in both modes.
- Stall: with out_ready=0, out_data and out_valid hold stable; data never changes while out_valid && !out_ready.
- SKID=1 backpressure: when out_ready is low, one additional input is absorbed before in_ready falls. in_ready then returns one cycle after the draining transfer.
- Flush: out_valid=0 in the cycle after flush is asserted. The first new entry can be accepted in the cycle after flush deasserts.
- rst mid-transfer: all entries are lost and the state matches the reset values on the next cycle.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 and in_data=0xAA → out_valid=0, out_data=BUBBLE, count=0. After release, in_ready=1.
- Streaming, SKID=1 and SKID=0: out_ready=1, in_data=1,2,3,... every cycle → out_data follows one cycle later, no gaps, count stays at 1.
- Skid fill/drain, SKID=1: main holds 0x10, out_ready=0, push 0x11 → count=2 and in_ready=0 next cycle. Raise out_ready → outputs 0x10 then 0x11, with in_ready=1 one cycle after the first drain.
- Flush with input: count=2, flush=1 together with in_valid=1 and in_data=0x55 → next cycle out_valid=0, out_data=BUBBLE, count=0, and 0x55 never appears.
- Stall stability: out_valid=1 with data 0xDEAD, out_ready=0 for 5 cycles → out_data is 0xDEAD in every cycle.
- SKID=0 pass-through: main full, out_ready toggling → in_ready equals out_ready in the same cycle and ordering is preserved.
